// File: rtl/cnvrow_sched.sv
// Row-level sequencer for one CNVROW unit: walks LENROW columns x NumBlk channel blocks,
// handshaking block data, the three MACAW engines and the incoming partial sum.
module cnvrow_sched #(
    parameter int LENROW  = 16,
    parameter int BLK_W   = 6,
    parameter int COL_W   = 4,
    parameter int FNH_TMO = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             CFG_Sta,
    input  logic [BLK_W-1:0] CFG_NumBlk,
    input  logic             CFG_Abt,
    input  logic             BUFPEC_DatVld,
    output logic             PECBUF_DatRdy,
    input  logic             PSUM_Vld,
    output logic             PECPSUM_Rdy,
    output logic             PECMAC_Sta,
    input  logic             MACPEC_Fnh0,
    input  logic             MACPEC_Fnh1,
    input  logic             MACPEC_Fnh2,
    output logic             PECCNV_PlsAcc,
    output logic             PECCNV_FnhRow,
    output logic             Row_Busy,
    output logic             Row_Done,
    output logic             Row_Err,
    output logic [COL_W-1:0] Cur_Col,
    output logic [BLK_W-1:0] Cur_Blk
);

    localparam int TMO_W = (FNH_TMO < 2) ? 1 : $clog2(FNH_TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DAT,
        S_STA,
        S_WAIT_FNH,
        S_WAIT_PSUM,
        S_ACC,
        S_FNH
    } state_t;

    state_t             r_state;
    state_t             w_nxt;
    logic [BLK_W-1:0]   r_numblk;
    logic [COL_W-1:0]   r_col;
    logic [BLK_W-1:0]   r_blk;
    logic [2:0]         r_sticky;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_err;
    logic               r_sta;
    logic               r_acc;
    logic               r_fnh;
    logic               r_busy;

    logic [2:0]         w_fnh;
    logic               w_fnh_all;
    logic               w_blk_last;
    logic               w_col_last;
    logic               w_tmo_hit;
    logic               w_abort;

    assign w_fnh      = {MACPEC_Fnh2, MACPEC_Fnh1, MACPEC_Fnh0};
    // A finish arriving in the same cycle as the last missing sticky bit still closes the block.
    assign w_fnh_all  = &(r_sticky | w_fnh);
    assign w_blk_last = (r_blk == r_numblk - BLK_W'(1));
    assign w_col_last = (r_col == COL_W'(LENROW - 1));
    assign w_tmo_hit  = (r_tmo == TMO_W'(FNH_TMO - 1));
    assign w_abort    = CFG_Abt && (r_state != S_IDLE);

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:      if (CFG_Sta) w_nxt = S_WAIT_DAT;
            S_WAIT_DAT:  if (BUFPEC_DatVld) w_nxt = S_STA;
            S_STA:       w_nxt = S_WAIT_FNH;
            S_WAIT_FNH: begin
                if (w_fnh_all)
                    w_nxt = w_blk_last ? S_WAIT_PSUM : S_WAIT_DAT;
                else if (w_tmo_hit)
                    w_nxt = S_IDLE;
            end
            S_WAIT_PSUM: if (PSUM_Vld) w_nxt = S_ACC;
            S_ACC:       w_nxt = w_col_last ? S_FNH : S_WAIT_DAT;
            S_FNH:       w_nxt = S_IDLE;
            default:     w_nxt = S_IDLE;
        endcase
        // Abort overrides timeout and every normal transition.
        if (w_abort)
            w_nxt = S_IDLE;
    end

    // Outputs are decoded from the next state and registered, so they track the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_numblk <= '0;
            r_col    <= '0;
            r_blk    <= '0;
            r_sticky <= '0;
            r_tmo    <= '0;
            r_err    <= 1'b0;
            r_sta    <= 1'b0;
            r_acc    <= 1'b0;
            r_fnh    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_sta   <= (w_nxt == S_STA);
            r_acc   <= (w_nxt == S_ACC);
            r_fnh   <= (w_nxt == S_FNH);
            r_busy  <= (w_nxt != S_IDLE);

            if (w_abort) begin
                r_col    <= '0;
                r_blk    <= '0;
                r_sticky <= '0;
                r_tmo    <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (CFG_Sta) begin
                            r_numblk <= (CFG_NumBlk == '0) ? BLK_W'(1) : CFG_NumBlk;
                            r_col    <= '0;
                            r_blk    <= '0;
                            r_err    <= 1'b0;
                        end
                    end
                    S_STA: begin
                        r_sticky <= '0;
                        r_tmo    <= '0;
                    end
                    S_WAIT_FNH: begin
                        r_sticky <= r_sticky | w_fnh;
                        if (w_fnh_all) begin
                            if (!w_blk_last)
                                r_blk <= r_blk + BLK_W'(1);
                        end else if (w_tmo_hit) begin
                            r_err <= 1'b1;
                            r_col <= '0;
                            r_blk <= '0;
                        end else begin
                            r_tmo <= r_tmo + TMO_W'(1);
                        end
                    end
                    S_ACC: begin
                        r_blk <= '0;
                        if (!w_col_last)
                            r_col <= r_col + COL_W'(1);
                    end
                    S_FNH: begin
                        r_col <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign PECMAC_Sta    = r_sta;
    assign PECBUF_DatRdy = r_sta;
    assign PECCNV_PlsAcc = r_acc;
    assign PECPSUM_Rdy   = r_acc;
    assign PECCNV_FnhRow = r_fnh;
    assign Row_Done      = r_fnh;
    assign Row_Busy      = r_busy;
    assign Row_Err       = r_err;
    assign Cur_Col       = r_col;
    assign Cur_Blk       = r_blk;

endmodule

// File: tb/tb_cnvrow_sched.sv
// Scoreboard bench for cnvrow_sched: expected pulses (cycle, kind, column, block) are queued
// by the stimulus and consumed by a monitor whenever the DUT emits a pulse.
module tb_cnvrow_sched;

    localparam int LENROW  = 4;
    localparam int BLK_W   = 6;
    localparam int COL_W   = 4;
    localparam int FNH_TMO = 8;

    localparam logic [5:0] B_STA = 6'b110000;
    localparam logic [5:0] B_ACC = 6'b001100;
    localparam logic [5:0] B_FNH = 6'b000011;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             CFG_Sta = 1'b0;
    logic [BLK_W-1:0] CFG_NumBlk = '0;
    logic             CFG_Abt = 1'b0;
    logic             BUFPEC_DatVld = 1'b0;
    logic             PECBUF_DatRdy;
    logic             PSUM_Vld = 1'b0;
    logic             PECPSUM_Rdy;
    logic             PECMAC_Sta;
    logic             MACPEC_Fnh0 = 1'b0;
    logic             MACPEC_Fnh1 = 1'b0;
    logic             MACPEC_Fnh2 = 1'b0;
    logic             PECCNV_PlsAcc;
    logic             PECCNV_FnhRow;
    logic             Row_Busy;
    logic             Row_Done;
    logic             Row_Err;
    logic [COL_W-1:0] Cur_Col;
    logic [BLK_W-1:0] Cur_Blk;

    cnvrow_sched #(
        .LENROW (LENROW),
        .BLK_W  (BLK_W),
        .COL_W  (COL_W),
        .FNH_TMO(FNH_TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .CFG_Sta      (CFG_Sta),
        .CFG_NumBlk   (CFG_NumBlk),
        .CFG_Abt      (CFG_Abt),
        .BUFPEC_DatVld(BUFPEC_DatVld),
        .PECBUF_DatRdy(PECBUF_DatRdy),
        .PSUM_Vld     (PSUM_Vld),
        .PECPSUM_Rdy  (PECPSUM_Rdy),
        .PECMAC_Sta   (PECMAC_Sta),
        .MACPEC_Fnh0  (MACPEC_Fnh0),
        .MACPEC_Fnh1  (MACPEC_Fnh1),
        .MACPEC_Fnh2  (MACPEC_Fnh2),
        .PECCNV_PlsAcc(PECCNV_PlsAcc),
        .PECCNV_FnhRow(PECCNV_FnhRow),
        .Row_Busy     (Row_Busy),
        .Row_Done     (Row_Done),
        .Row_Err      (Row_Err),
        .Cur_Col      (Cur_Col),
        .Cur_Blk      (Cur_Blk)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [5:0] bits;
        int         col;
        int         blk;
    } ev_t;

    ev_t q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  last_sta = -1000;
    int  d0 = 1, d1 = 1, d2 = 1, dup0 = 0;
    bit  en2 = 1'b1, dup_en = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // MACAW responder: finish pulses at fixed offsets after the observed start pulse.
    initial forever begin
        @(posedge clk);
        #1;
        MACPEC_Fnh0 = (cyc == last_sta + d0) || (dup_en && cyc == last_sta + dup0);
        MACPEC_Fnh1 = (cyc == last_sta + d1);
        MACPEC_Fnh2 = en2 && (cyc == last_sta + d2);
    end

    initial begin
        ev_t        e;
        logic [5:0] w;
        forever begin
            @(negedge clk);
            w = {PECMAC_Sta, PECBUF_DatRdy, PECCNV_PlsAcc, PECPSUM_Rdy, PECCNV_FnhRow, Row_Done};
            if (w != 6'd0) begin
                if (PECMAC_Sta) last_sta = cyc;
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL pulse_unexpected: cyc=%0d bits=%b col=%0d blk=%0d, required no pulse",
                             cyc, w, Cur_Col, Cur_Blk);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || e.bits != w || e.col != int'(Cur_Col) || e.blk != int'(Cur_Blk)) begin
                        n_bad++;
                        $display("FAIL pulse: got cyc=%0d bits=%b col=%0d blk=%0d, required cyc=%0d bits=%b col=%0d blk=%0d",
                                 cyc, w, Cur_Col, Cur_Blk, e.cyc, e.bits, e.col, e.blk);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic void push(input int c, input logic [5:0] b, input int col, input int blk);
        ev_t e;
        e.cyc = c; e.bits = b; e.col = col; e.blk = blk;
        q.push_back(e);
    endfunction

    function automatic int outs();
        return int'({PECBUF_DatRdy, PECPSUM_Rdy, PECMAC_Sta, PECCNV_PlsAcc, PECCNV_FnhRow,
                     Row_Busy, Row_Done, Row_Err, Cur_Col, Cur_Blk});
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d (cyc=%0d)", nm, act, req, cyc);
        end
    endtask

    task automatic drv_at(input int t);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < t);
    endtask

    task automatic at_cyc(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic go(input int nb, output int base);
        base       = cyc;
        CFG_NumBlk = BLK_W'(nb);
        CFG_Sta    = 1'b1;
        @(posedge clk);
        #1;
        CFG_Sta    = 1'b0;
    endtask

    initial begin
        int b;
        int b2;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 0);
        rst = 1'b0;
        drv_at(cyc + 1);
        BUFPEC_DatVld = 1'b1;
        PSUM_Vld      = 1'b1;

        // Nominal row: NumBlk=2, finishes one cycle after each start, stray CFG_Sta mid-row.
        go(2, b);
        for (int c = 0; c < LENROW; c++) begin
            push(b + 8*c + 2, B_STA, c, 0);
            push(b + 8*c + 5, B_STA, c, 1);
            push(b + 8*c + 8, B_ACC, c, 1);
        end
        push(b + 33, B_FNH, 3, 0);
        drv_at(b + 11);
        CFG_Sta = 1'b1; CFG_NumBlk = 6'd5;
        drv_at(b + 12);
        CFG_Sta = 1'b0;
        at_cyc(b + 33);
        chk("nom_busy_at_fnh", int'(Row_Busy), 1);
        at_cyc(b + 34);
        chk("nom_busy_after", int'(Row_Busy), 0);
        chk("nom_col_after", int'(Cur_Col), 0);
        drv_at(b + 36);

        // Staggered finishes with a duplicate Fnh0.
        d0 = 1; d1 = 4; d2 = 2; dup_en = 1'b1; dup0 = 3;
        go(2, b);
        for (int c = 0; c < LENROW; c++) begin
            push(b + 14*c + 2,  B_STA, c, 0);
            push(b + 14*c + 8,  B_STA, c, 1);
            push(b + 14*c + 14, B_ACC, c, 1);
        end
        push(b + 57, B_FNH, 3, 0);
        at_cyc(b + 6);
        chk("stag_blk_in_fnh", int'(Cur_Blk), 0);
        at_cyc(b + 7);
        chk("stag_blk_next", int'(Cur_Blk), 1);
        at_cyc(b + 58);
        chk("stag_busy_after", int'(Row_Busy), 0);
        drv_at(b + 60);
        d1 = 1; d2 = 1; dup_en = 1'b0;

        // Backpressure in column 1.
        go(2, b);
        push(b + 2,  B_STA, 0, 0); push(b + 5,  B_STA, 0, 1); push(b + 8,  B_ACC, 0, 1);
        push(b + 15, B_STA, 1, 0); push(b + 18, B_STA, 1, 1); push(b + 24, B_ACC, 1, 1);
        push(b + 26, B_STA, 2, 0); push(b + 29, B_STA, 2, 1); push(b + 32, B_ACC, 2, 1);
        push(b + 34, B_STA, 3, 0); push(b + 37, B_STA, 3, 1); push(b + 40, B_ACC, 3, 1);
        push(b + 41, B_FNH, 3, 0);
        drv_at(b + 9);  BUFPEC_DatVld = 1'b0;
        drv_at(b + 12);
        chk("bp_col_during_stall", int'(Cur_Col), 1);
        drv_at(b + 14); BUFPEC_DatVld = 1'b1;
        drv_at(b + 20); PSUM_Vld = 1'b0;
        drv_at(b + 23); PSUM_Vld = 1'b1;
        at_cyc(b + 42);
        chk("bp_busy_after", int'(Row_Busy), 0);
        drv_at(b + 44);

        // NumBlk=0 behaves as one block per column.
        go(0, b);
        for (int c = 0; c < LENROW; c++) begin
            push(b + 5*c + 2, B_STA, c, 0);
            push(b + 5*c + 5, B_ACC, c, 0);
        end
        push(b + 21, B_FNH, 3, 0);
        at_cyc(b + 22);
        chk("nb0_busy_after", int'(Row_Busy), 0);
        drv_at(b + 24);

        // Abort in WAIT_FNH of column 2, coincident with all finishes.
        go(2, b);
        push(b + 2,  B_STA, 0, 0); push(b + 5,  B_STA, 0, 1); push(b + 8,  B_ACC, 0, 1);
        push(b + 10, B_STA, 1, 0); push(b + 13, B_STA, 1, 1); push(b + 16, B_ACC, 1, 1);
        push(b + 18, B_STA, 2, 0);
        drv_at(b + 19);
        chk("abt_col_before", int'(Cur_Col), 2);
        CFG_Abt = 1'b1;
        drv_at(b + 20);
        CFG_Abt = 1'b0;
        at_cyc(b + 20);
        chk("abt_busy", int'(Row_Busy), 0);
        chk("abt_col", int'(Cur_Col), 0);
        chk("abt_blk", int'(Cur_Blk), 0);
        chk("abt_err", int'(Row_Err), 0);
        drv_at(b + 26);
        // Restart with abort held in IDLE: it must not block the start.
        CFG_Abt = 1'b1;
        go(1, b2);
        CFG_Abt = 1'b0;
        for (int c = 0; c < LENROW; c++) begin
            push(b2 + 5*c + 2, B_STA, c, 0);
            push(b2 + 5*c + 5, B_ACC, c, 0);
        end
        push(b2 + 21, B_FNH, 3, 0);
        at_cyc(b2 + 22);
        chk("restart_busy_after", int'(Row_Busy), 0);
        drv_at(b2 + 24);

        // Timeout: Fnh2 never arrives.
        en2 = 1'b0;
        go(1, b);
        push(b + 2, B_STA, 0, 0);
        at_cyc(b + 10);
        chk("tmo_busy_last_wait", int'(Row_Busy), 1);
        chk("tmo_err_early", int'(Row_Err), 0);
        at_cyc(b + 11);
        chk("tmo_busy", int'(Row_Busy), 0);
        chk("tmo_err", int'(Row_Err), 1);
        drv_at(b + 14);
        chk("tmo_err_sticky", int'(Row_Err), 1);
        en2 = 1'b1;
        go(1, b2);
        chk("err_cleared_by_sta", int'(Row_Err), 0);
        chk("busy_after_sta", int'(Row_Busy), 1);

        // Reset in the STA cycle clears every output at once.
        drv_at(b2 + 2);
        chk("sta_before_rst", int'(PECMAC_Sta), 1);
        rst = 1'b1;
        #1;
        chk("rst_outputs", outs(), 0);
        drv_at(b2 + 5);
        rst = 1'b0;
        drv_at(b2 + 15);
        chk("post_rst_outputs", outs(), 0);

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: %0d expected pulses never seen, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
